dff_response_checker: RTL and testbench
=======================================

Name: dff_response_checker

Overview:
- Synthesizable receiving end of the A/B flip-flop stimulus stream.
- Samples the same A and B inputs that drive the flip-flop under test and keeps its own golden model of that flip-flop.
- Compares the DUT outputs Y (true) and Z (complement) on every clock, counts mismatches, and records the first failing sample index.
- Reports PASS/DONE after a fixed number of samples.
- Sits beside the flip-flop on the lab board or in the fixture.

Parameters:
- N_SAMPLES, 16, number of compared clock edges per run (1..255).
- CNT_W, 8, width of the sample, error and index counters.
- D_FUNC, 0, golden next-state function: 0 → D=A; 1 → D=A&B; 2 → D=A^B; 3 → D=A when B=1, else hold.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse that begins a run (ignored unless IDLE or DONE).
- A  in  1  stimulus bit A, same net as the DUT input.
- B  in  1  stimulus bit B, same net as the DUT input.
- Y  in  1  DUT true output.
- Z  in  1  DUT complement output.
- BUSY  out  1  high in ARM and RUN.
- DONE  out  1  high in DONE state.
- PASS  out  1  valid when DONE=1; 1 iff ERR_CNT==0.
- ERR_CNT  out  CNT_W  saturating mismatch count.
- FIRST_ERR  out  CNT_W  sample index of the first mismatch; all-ones if none.
- EXP_Q  out  1  current golden-model state, for debug.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR=all-ones, EXP_Q=0, sample counter=0.
- States:
  - IDLE –START→ ARM.
  - ARM –next edge→ RUN.
  - RUN –sample counter reaches N_SAMPLES→ DONE.
  - DONE –START→ ARM.
- ARM: one clock.
  - EXP_Q loads next-state(A,B,EXP_Q) per D_FUNC.
  - No comparison; the DUT state is unknown before the first capture.
  - Clears ERR_CNT, FIRST_ERR and the sample counter.
- RUN, every rising edge:
  - Compare Y against EXP_Q, and Z against ~EXP_Q, both registered one edge earlier.
  - Mismatch = (Y!=EXP_Q) | (Z!=~EXP_Q).
  - X/Z on Y or Z counts as a mismatch in simulation.
  - Then EXP_Q updates from the current A, B.
  - Sample counter increments.
- Comparison latency: one clock. The DUT output observed at edge k must equal the golden state computed at edge k-1.
- ERR_CNT increments on mismatch and saturates at 2^CNT_W-1; no wrap.
- FIRST_ERR is written only while it still holds all-ones, with the current sample index (0-based).
- Last sample:
  - When the counter equals N_SAMPLES-1 at an edge, that edge's comparison is counted.
  - The state enters DONE on that edge.
  - PASS is computed from the updated count, so it is valid in the same cycle DONE rises.
- DONE holds all results stable until START or reset. A, B, Y, Z are ignored.
- START during ARM/RUN is ignored; a run is never restarted mid-way.
- START in DONE re-arms; results clear in ARM, not before.
- Reset mid-run aborts immediately to the reset values; no partial results are retained.
- D_FUNC=3 hold case: EXP_Q is unchanged when B=0.
- Only D_FUNC values 0..3 are legal; any other value is treated as 0.

Decomposition:
- Shared package `dff_chk_pkg`:
  - State encoding: IDLE=2'd0, ARM=2'd1, RUN=2'd2, DONE=2'd3.
  - D_FUNC constants.
  - Function `golden_next(a, b, q, func)`.
- One natural sub-module, `dff_golden_model`:
  - Registered EXP_Q with async active-low reset.
  - Load enable from the checker FSM.
- Counters and FSM stay in the top.

Test Plan:
- Correct DUT, D_FUNC=0, N_SAMPLES=16, A toggling each cycle, Y=previous A, Z=~Y → DONE after 17 edges post-START, PASS=1, ERR_CNT=0, FIRST_ERR=8'hFF.
- Inject one error: force Y inverted at sample 5 only → ERR_CNT=1, FIRST_ERR=5, PASS=0.
- Z stuck at 0 with Y correct → mismatch whenever EXP_Q=0; with alternating A, ERR_CNT=8, FIRST_ERR is the first index where EXP_Q=0.
- D_FUNC=3, B=0 for samples 3..6 while A toggles, DUT holds → PASS=1; same with DUT following A → ERR_CNT≥2.
- Saturation: CNT_W=4, N_SAMPLES=20, Y permanently wrong → ERR_CNT=15, no wrap.
- Mid-run events:
  - RST_N low at sample 7 → all outputs return to reset values immediately.
  - START at sample 7 (no reset) → ignored; DONE still at sample 16.

Source files
------------

// File: rtl/dff_chk_pkg.sv
// Shared definitions for the flip-flop response checker: FSM states,
// golden next-state function selectors and the golden next-state function.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } chk_state_t;

    localparam int DF_PASS = 0;  // D = A
    localparam int DF_AND  = 1;  // D = A & B
    localparam int DF_XOR  = 2;  // D = A ^ B
    localparam int DF_HOLD = 3;  // D = A when B, else hold

    // Unknown selector values fall back to the plain D = A flip-flop.
    function automatic logic golden_next(input logic a, input logic b,
                                         input logic q, input int func);
        case (func)
            DF_PASS: return a;
            DF_AND:  return a & b;
            DF_XOR:  return a ^ b;
            DF_HOLD: return b ? a : q;
            default: return a;
        endcase
    endfunction

endpackage

// File: rtl/dff_golden_model.sv
// Golden copy of the flip-flop under test; one-clock update when load is high.
// No backpressure: state simply holds while load is low.
module dff_golden_model
    import dff_chk_pkg::*;
#(
    parameter int D_FUNC = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic a,
    input  logic b,
    output logic exp_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= 1'b0;
        end else if (load) begin
            exp_q <= golden_next(a, b, exp_q, D_FUNC);
        end
    end

endmodule

// File: rtl/dff_response_checker.sv
// Compares DUT Y/Z against a golden flip-flop one clock behind; counts errors.
// Results registered, PASS valid with DONE; START ignored while a run is in flight.
module dff_response_checker
    import dff_chk_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int CNT_W     = 8,
    parameter int D_FUNC    = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             A,
    input  logic             B,
    input  logic             Y,
    input  logic             Z,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] FIRST_ERR,
    output logic             EXP_Q
);

    // Sample counter is sized from N_SAMPLES so runs longer than 2^CNT_W still terminate.
    localparam int               SMP_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    chk_state_t       state;
    logic [SMP_W-1:0] smp_cnt;
    logic             load;
    logic             mismatch;
    logic [CNT_W-1:0] err_nxt;

    assign load = (state == ST_ARM) || (state == ST_RUN);

    dff_golden_model #(
        .D_FUNC(D_FUNC)
    ) u_golden (
        .clk  (CLK),
        .rst_n(RST_N),
        .load (load),
        .a    (A),
        .b    (B),
        .exp_q(EXP_Q)
    );

    // Case matching is exact, so an X/Z on Y or Z falls to the mismatch arm.
    always_comb begin
        mismatch = 1'b1;
        case ({Y, Z})
            {EXP_Q, ~EXP_Q}: mismatch = 1'b0;
            default:         mismatch = 1'b1;
        endcase
    end

    always_comb begin
        err_nxt = ERR_CNT;
        if (mismatch && (ERR_CNT != ALL_ONES)) begin
            err_nxt = ERR_CNT + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            ERR_CNT   <= '0;
            FIRST_ERR <= ALL_ONES;
            smp_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state <= ST_ARM;
                        BUSY  <= 1'b1;
                        DONE  <= 1'b0;
                    end
                end
                ST_ARM: begin
                    state     <= ST_RUN;
                    PASS      <= 1'b0;
                    ERR_CNT   <= '0;
                    FIRST_ERR <= ALL_ONES;
                    smp_cnt   <= '0;
                end
                ST_RUN: begin
                    ERR_CNT <= err_nxt;
                    if (mismatch && (FIRST_ERR == ALL_ONES)) begin
                        FIRST_ERR <= CNT_W'(smp_cnt);
                    end
                    smp_cnt <= smp_cnt + 1'b1;
                    if (smp_cnt == LAST_SMP) begin
                        state <= ST_DONE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        PASS  <= (err_nxt == '0);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_response_checker.sv
// Three checker instances (D=A, hold-on-B, A&B with 4-bit counters) fed by an emulated flip-flop.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_dff_response_checker;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST_N, START, A, B;
    logic y [3];
    logic z [3];
    logic busy [3];
    logic done_o [3];
    logic pass [3];
    logic expq [3];
    logic [7:0] err0, err1, first0, first1;
    logic [3:0] err2, first2;

    dff_response_checker #(.N_SAMPLES(16), .CNT_W(8), .D_FUNC(0)) u0 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .Y(y[0]), .Z(z[0]),
        .BUSY(busy[0]), .DONE(done_o[0]), .PASS(pass[0]), .ERR_CNT(err0),
        .FIRST_ERR(first0), .EXP_Q(expq[0]));

    dff_response_checker #(.N_SAMPLES(16), .CNT_W(8), .D_FUNC(3)) u3 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .Y(y[1]), .Z(z[1]),
        .BUSY(busy[1]), .DONE(done_o[1]), .PASS(pass[1]), .ERR_CNT(err1),
        .FIRST_ERR(first1), .EXP_Q(expq[1]));

    dff_response_checker #(.N_SAMPLES(20), .CNT_W(4), .D_FUNC(1)) us (
        .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B), .Y(y[2]), .Z(z[2]),
        .BUSY(busy[2]), .DONE(done_o[2]), .PASS(pass[2]), .ERR_CNT(err2),
        .FIRST_ERR(first2), .EXP_Q(expq[2]));

    int nsamp [3] = '{16, 16, 20};
    int maxv  [3] = '{255, 255, 15};
    int func  [3] = '{0, 3, 1};

    // Behavioural model: phase 0 idle, 1 arm, 2 run, 3 done.
    int m_st [3];
    int m_q [3];
    int m_err [3];
    int m_first [3];
    int m_idx [3];
    int m_pass [3];

    int ff_q [3];   // emulated flip-flop under test
    int mode [3];   // 0 ok,1 Y flip at sample 5,2 Z stuck 0,3 follows A,4 Y always wrong,5 random faults
    int pos;
    int n_cmp = 0;
    int n_bad = 0;
    int done_at;

    function automatic int gn(input int a, input int b, input int q, input int f);
        case (f)
            1: return a & b;
            2: return a ^ b;
            3: return (b != 0) ? a : q;
            default: return a;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_q[k] = 0; m_err[k] = 0;
            m_first[k] = maxv[k]; m_idx[k] = 0; m_pass[k] = 0;
        end
    endtask

    task automatic model_step();
        logic eq, bad;
        if (!RST_N) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if ((m_st[k] == 0 || m_st[k] == 3) && START) begin
                m_st[k] = 1;
            end else if (m_st[k] == 1) begin
                m_q[k] = gn(A, B, m_q[k], func[k]);
                m_err[k] = 0; m_first[k] = maxv[k]; m_idx[k] = 0; m_pass[k] = 0;
                m_st[k] = 2;
            end else if (m_st[k] == 2) begin
                eq  = m_q[k][0];
                bad = (y[k] !== eq) || (z[k] !== ~eq);
                if (bad && m_err[k] < maxv[k]) m_err[k]++;
                if (bad && m_first[k] == maxv[k]) m_first[k] = m_idx[k] & maxv[k];
                m_q[k] = gn(A, B, m_q[k], func[k]);
                if (m_idx[k] == nsamp[k] - 1) begin
                    m_st[k] = 3;
                    m_pass[k] = (m_err[k] == 0) ? 1 : 0;
                end
                m_idx[k]++;
            end
        end
    endtask

    task automatic check_inst(input int k, input logic bs, input logic dn, input logic ps,
                              input logic [7:0] er, input logic [7:0] fe, input logic eq);
        chk($sformatf("busy%0d", k),  8'(bs), 8'(m_st[k] == 1 || m_st[k] == 2));
        chk($sformatf("done%0d", k),  8'(dn), 8'(m_st[k] == 3));
        chk($sformatf("pass%0d", k),  8'(ps), 8'(m_pass[k]));
        chk($sformatf("err%0d", k),   er, 8'(m_err[k]));
        chk($sformatf("first%0d", k), fe, 8'(m_first[k]));
        chk($sformatf("expq%0d", k),  8'(eq), 8'(m_q[k] & 1));
    endtask

    task automatic compare_all();
        check_inst(0, busy[0], done_o[0], pass[0], err0, first0, expq[0]);
        check_inst(1, busy[1], done_o[1], pass[1], err1, first1, expq[1]);
        check_inst(2, busy[2], done_o[2], pass[2], {4'h0, err2}, {4'h0, first2}, expq[2]);
    endtask

    task automatic drive_yz();
        logic q;
        int r;
        for (int k = 0; k < 3; k++) begin
            q = ff_q[k][0];
            y[k] = q;
            z[k] = ~q;
            case (mode[k])
                1: if (pos - 1 == 5) y[k] = ~q;
                2: z[k] = 1'b0;
                4: y[k] = ~q;
                5: begin
                    r = $urandom_range(0, 15);
                    if (r < 2)       y[k] = ~q;
                    else if (r < 4)  z[k] = q;
                    else if (r == 4) y[k] = 1'bx;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        for (int k = 0; k < 3; k++)
            ff_q[k] = (mode[k] == 3) ? int'(A) : gn(A, B, ff_q[k], func[k]);
        @(negedge CLK);
        compare_all();
    endtask

    // pat: 0 A toggles, 1 A toggles with B=0 on samples 3..6, 2 random.
    // evt: 1 START at sample 7, 2 reset at sample 7.
    task automatic do_run(input int m0, input int m1, input int m2, input int pat, input int evt);
        mode[0] = m0; mode[1] = m1; mode[2] = m2;
        pos = -100;
        START = 1'b1; B = 1'b1; A = 1'($urandom_range(0, 1));
        drive_yz();
        cycle();
        START = 1'b0;
        pos = 0;
        done_at = -1;
        for (int s = 0; s < 22; s++) begin
            if (pat == 2) begin
                A = 1'($urandom_range(0, 1));
                B = (pos == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                A = (pos % 2 == 0);
                B = !(pat == 1 && pos - 1 >= 3 && pos - 1 <= 6);
            end
            START = (evt == 1 && pos - 1 == 7);
            if (evt == 2 && pos - 1 == 7) begin
                RST_N = 1'b0;
                #1;
                model_reset();
                compare_all();
                chk("midrst_busy0", 8'(busy[0]), 8'h00);
                chk("midrst_err0", err0, 8'h00);
                chk("midrst_first0", first0, 8'hFF);
                chk("midrst_expq0", 8'(expq[0]), 8'h00);
                cycle();
                RST_N = 1'b1;
                START = 1'b0;
                return;
            end
            drive_yz();
            cycle();
            pos++;
            if (done_o[0] && done_at < 0) done_at = pos;
        end
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; A = 1'b0; B = 1'b1; pos = -100;
        for (int k = 0; k < 3; k++) begin mode[k] = 0; ff_q[k] = 0; end
        model_reset();
        drive_yz();
        @(negedge CLK);
        compare_all();
        chk("rst_first0", first0, 8'hFF);
        chk("rst_first2", {4'h0, first2}, 8'h0F);
        chk("rst_busy0", 8'(busy[0]), 8'h00);
        cycle();
        RST_N = 1'b1;
        cycle();
        cycle();

        do_run(0, 0, 4, 0, 0);
        chk("r1_pass0", 8'(pass[0]), 8'h01);
        chk("r1_err0", err0, 8'h00);
        chk("r1_first0", first0, 8'hFF);
        chk("r1_done_at", 8'(done_at), 8'd17);
        chk("r1_sat_err2", {4'h0, err2}, 8'h0F);
        chk("r1_first2", {4'h0, first2}, 8'h00);
        chk("r1_pass2", 8'(pass[2]), 8'h00);

        do_run(1, 0, 5, 0, 0);
        chk("r2_err0", err0, 8'h01);
        chk("r2_first0", first0, 8'h05);
        chk("r2_pass0", 8'(pass[0]), 8'h00);

        do_run(2, 0, 5, 0, 0);
        chk("r3_err0", err0, 8'h08);
        chk("r3_first0", first0, 8'h01);

        do_run(0, 0, 0, 1, 0);
        chk("r4_pass1", 8'(pass[1]), 8'h01);
        chk("r4_err1", err1, 8'h00);

        do_run(0, 3, 0, 1, 0);
        chk("r5_err1", err1, 8'h02);
        chk("r5_first1", first1, 8'h04);
        chk("r5_pass1", 8'(pass[1]), 8'h00);

        do_run(0, 0, 0, 0, 1);
        chk("r6_done_at", 8'(done_at), 8'd17);
        chk("r6_pass0", 8'(pass[0]), 8'h01);

        do_run(5, 5, 5, 2, 2);
        repeat (2) cycle();

        for (int r = 0; r < 8; r++) begin
            do_run(5, 5, 5, 2, 0);
        end
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
